// File: rtl/riscv_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// riscv_constants
// Shared encodings for the kana-riscv write-back stage:
//   wb_sel_t     - result source select (ALU, load data, PC+4, CSR)
//   load_funct_t - RISC-V load funct3 encodings
//   wb_state_t   - write-back stage FSM states
//   effective_load_funct - maps a raw funct3 onto the load actually performed
// ---------------------------------------------------------------------------
package riscv_constants;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } load_funct_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    // LD and LWU only exist on a 64-bit datapath; anything not legal for the
    // configured width (including the unused 111 code) behaves as LW.
    function automatic load_funct_t effective_load_funct(input logic [2:0] funct3,
                                                         input logic       wide);
        load_funct_t lf;
        case (funct3)
            3'b000:  lf = LB;
            3'b001:  lf = LH;
            3'b010:  lf = LW;
            3'b100:  lf = LBU;
            3'b101:  lf = LHU;
            3'b011:  lf = wide ? LD  : LW;
            3'b110:  lf = wide ? LWU : LW;
            default: lf = LW;
        endcase
        return lf;
    endfunction

endpackage

// File: rtl/riscv_wb_stage_load_align.sv
// ---------------------------------------------------------------------------
// riscv_load_align
// Combinational load data alignment and extension.
//   mem_rdata  - raw naturally aligned word from memory
//   addr_lo    - byte offset of the load inside that word
//   funct3     - load type
//   load_data  - data shifted down to bit 0 and sign/zero-extended
//   misaligned - access is not naturally aligned for its size
// ---------------------------------------------------------------------------
module riscv_load_align
    import riscv_constants::*;
#(
    parameter  int WORD_LENGTH = 32,
    localparam int AL_W        = $clog2(WORD_LENGTH / 8)
) (
    input  logic [WORD_LENGTH-1:0] mem_rdata,
    input  logic [AL_W-1:0]        addr_lo,
    input  logic [2:0]             funct3,
    output logic [WORD_LENGTH-1:0] load_data,
    output logic                   misaligned
);

    load_funct_t            lf;
    logic [WORD_LENGTH-1:0] shifted;

    always_comb begin
        lf         = effective_load_funct(funct3, WORD_LENGTH == 64);
        shifted    = mem_rdata >> {addr_lo, 3'b000};
        load_data  = shifted;
        misaligned = 1'b0;
        // Size casts of signed slices give sign extension, unsigned ones zero.
        case (lf)
            LB:  load_data = WORD_LENGTH'($signed(shifted[7:0]));
            LBU: load_data = WORD_LENGTH'(shifted[7:0]);
            LH: begin
                load_data  = WORD_LENGTH'($signed(shifted[15:0]));
                misaligned = addr_lo[0];
            end
            LHU: begin
                load_data  = WORD_LENGTH'(shifted[15:0]);
                misaligned = addr_lo[0];
            end
            LW: begin
                load_data  = WORD_LENGTH'($signed(shifted[31:0]));
                misaligned = |addr_lo[1:0];
            end
            LWU: begin
                load_data  = WORD_LENGTH'(shifted[31:0]);
                misaligned = |addr_lo[1:0];
            end
            LD: begin
                load_data  = shifted;
                misaligned = |addr_lo;
            end
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_wb_stage.sv
// ---------------------------------------------------------------------------
// riscv_wb_stage
// Registered write-back stage: takes one instruction per handshake, picks its
// result (ALU / CSR / PC+4 / load data), waits for variable-latency load data
// when needed and produces a one-cycle register-file write.
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid/in_ready - upstream handshake; flush drops input / kills a load
//   wb_sel, load_funct3, addr_lo, alu_out, csr_rdata, pc_plus4,
//   rd_addr, rd_we    - instruction fields from the memory stage
//   mem_rvalid, mem_rdata - load response
//   rf_we, rf_waddr, rf_wdata - registered write port / forwarding bus
//   load_misaligned   - registered one-cycle exception pulse
//   busy              - a load is outstanding
// ---------------------------------------------------------------------------
module riscv_wb_stage
    import riscv_constants::*;
#(
    parameter  int WORD_LENGTH = 32,
    localparam int AL_W        = $clog2(WORD_LENGTH / 8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic [1:0]             wb_sel,
    input  logic [2:0]             load_funct3,
    input  logic [AL_W-1:0]        addr_lo,
    input  logic [WORD_LENGTH-1:0] alu_out,
    input  logic [WORD_LENGTH-1:0] csr_rdata,
    input  logic [WORD_LENGTH-1:0] pc_plus4,
    input  logic [4:0]             rd_addr,
    input  logic                   rd_we,
    input  logic                   mem_rvalid,
    input  logic [WORD_LENGTH-1:0] mem_rdata,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [WORD_LENGTH-1:0] rf_wdata,
    output logic                   load_misaligned,
    output logic                   busy
);

    wb_state_t              state, next_state;
    logic [4:0]             pend_rd;
    logic                   pend_we;
    logic [2:0]             pend_funct3;
    logic [AL_W-1:0]        pend_addr_lo;

    logic [AL_W-1:0]        align_addr_lo;
    logic [2:0]             align_funct3;
    logic [WORD_LENGTH-1:0] load_data;
    logic                   misaligned;

    logic                   accept;
    logic [WORD_LENGTH-1:0] src_data;
    logic                   next_we;
    logic [4:0]             next_waddr;
    logic [WORD_LENGTH-1:0] next_wdata;
    logic                   next_misaligned;
    logic                   update_result;
    logic                   capture_pending;

    assign in_ready = (state == IDLE);
    assign busy     = (state == WAIT_MEM);
    assign accept   = in_valid & in_ready & ~flush;

    // While waiting, the aligner must see the latched load fields, since the
    // upstream inputs may already belong to the next instruction.
    assign align_addr_lo = (state == WAIT_MEM) ? pend_addr_lo : addr_lo;
    assign align_funct3  = (state == WAIT_MEM) ? pend_funct3  : load_funct3;

    riscv_load_align #(
        .WORD_LENGTH(WORD_LENGTH)
    ) u_load_align (
        .mem_rdata (mem_rdata),
        .addr_lo   (align_addr_lo),
        .funct3    (align_funct3),
        .load_data (load_data),
        .misaligned(misaligned)
    );

    always_comb begin
        case (wb_sel_t'(wb_sel))
            WB_ALU:  src_data = alu_out;
            WB_MEM:  src_data = load_data;
            WB_PC:   src_data = pc_plus4;
            WB_CSR:  src_data = csr_rdata;
            default: src_data = alu_out;
        endcase
    end

    always_comb begin
        next_state      = state;
        next_we         = 1'b0;
        next_waddr      = rd_addr;
        next_wdata      = src_data;
        next_misaligned = 1'b0;
        update_result   = 1'b0;
        capture_pending = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (wb_sel_t'(wb_sel) != WB_MEM) begin
                        update_result = 1'b1;
                        next_we       = rd_we & (rd_addr != 5'd0);
                    end else if (misaligned) begin
                        next_misaligned = 1'b1;
                    end else if (mem_rvalid) begin
                        update_result = 1'b1;
                        next_we       = rd_we & (rd_addr != 5'd0);
                    end else begin
                        capture_pending = 1'b1;
                        next_state      = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                // Flush wins over a response arriving in the same cycle.
                if (flush) begin
                    next_state = IDLE;
                end else if (mem_rvalid) begin
                    update_result = 1'b1;
                    next_we       = pend_we & (pend_rd != 5'd0);
                    next_waddr    = pend_rd;
                    next_wdata    = load_data;
                    next_state    = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rf_we           <= 1'b0;
            rf_waddr        <= 5'd0;
            rf_wdata        <= '0;
            load_misaligned <= 1'b0;
            pend_rd         <= 5'd0;
            pend_we         <= 1'b0;
            pend_funct3     <= 3'd0;
            pend_addr_lo    <= '0;
        end else begin
            state           <= next_state;
            rf_we           <= next_we;
            load_misaligned <= next_misaligned;
            // Address and data hold between writes so the forwarding bus
            // keeps showing the last completed result.
            if (update_result) begin
                rf_waddr <= next_waddr;
                rf_wdata <= next_wdata;
            end
            if (capture_pending) begin
                pend_rd      <= rd_addr;
                pend_we      <= rd_we;
                pend_funct3  <= load_funct3;
                pend_addr_lo <= addr_lo;
            end
        end
    end

endmodule

// File: tb/tb_riscv_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_riscv_wb_stage
// Bench for riscv_wb_stage with a 32-bit and a 64-bit instance. Expected
// register-file writes are queued when an instruction is driven and matched
// against rf_we pulses; state outputs are compared at fixed cycles.
// ---------------------------------------------------------------------------
module tb_riscv_wb_stage;
    import riscv_constants::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid32, valid64, flush;
    logic [1:0]  wb_sel;
    logic [2:0]  load_funct3;
    logic [2:0]  addr_lo;
    logic [63:0] alu_out, csr_rdata, pc_plus4, mem_rdata;
    logic [4:0]  rd_addr;
    logic        rd_we, mem_rvalid;

    logic        ready32, rf_we32, mis32, busy32;
    logic [4:0]  rf_waddr32;
    logic [31:0] rf_wdata32;
    logic        ready64, rf_we64, mis64, busy64;
    logic [4:0]  rf_waddr64;
    logic [63:0] rf_wdata64;

    int          errors = 0;
    int          checks = 0;
    logic [68:0] q32[$];
    logic [68:0] q64[$];

    riscv_wb_stage #(.WORD_LENGTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(valid32), .in_ready(ready32), .flush(flush),
        .wb_sel(wb_sel), .load_funct3(load_funct3), .addr_lo(addr_lo[1:0]),
        .alu_out(alu_out[31:0]), .csr_rdata(csr_rdata[31:0]), .pc_plus4(pc_plus4[31:0]),
        .rd_addr(rd_addr), .rd_we(rd_we), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata[31:0]), .rf_we(rf_we32), .rf_waddr(rf_waddr32),
        .rf_wdata(rf_wdata32), .load_misaligned(mis32), .busy(busy32)
    );

    riscv_wb_stage #(.WORD_LENGTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(valid64), .in_ready(ready64), .flush(flush),
        .wb_sel(wb_sel), .load_funct3(load_funct3), .addr_lo(addr_lo),
        .alu_out(alu_out), .csr_rdata(csr_rdata), .pc_plus4(pc_plus4),
        .rd_addr(rd_addr), .rd_we(rd_we), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .rf_we(rf_we64), .rf_waddr(rf_waddr64),
        .rf_wdata(rf_wdata64), .load_misaligned(mis64), .busy(busy64)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one instruction; the chosen source gets 'result', the other
    // sources get its complement so a wrong select is visible.
    task automatic applyStimulus(input logic to64, input logic valid, input logic [1:0] sel,
                                 input logic [2:0] f3, input logic [2:0] alo,
                                 input logic [63:0] result, input logic [4:0] rd,
                                 input logic we, input logic mrv, input logic [63:0] mrd,
                                 input logic fl);
        valid32     = valid & ~to64;
        valid64     = valid & to64;
        wb_sel      = sel;
        load_funct3 = f3;
        addr_lo     = alo;
        alu_out     = (sel == WB_ALU) ? result : ~result;
        pc_plus4    = (sel == WB_PC)  ? result : ~result;
        csr_rdata   = (sel == WB_CSR) ? result : ~result;
        rd_addr     = rd;
        rd_we       = we;
        mem_rvalid  = mrv;
        mem_rdata   = mrd;
        flush       = fl;
    endtask

    task automatic driveIdle();
        applyStimulus(1'b0, 1'b0, WB_ALU, 3'd0, 3'd0, 64'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp32(input logic [4:0] rd, input logic [31:0] data);
        q32.push_back({rd, 32'd0, data});
    endtask

    task automatic pushExp64(input logic [4:0] rd, input logic [63:0] data);
        q64.push_back({rd, data});
    endtask

    // Scoreboards: every rf_we pulse must match the oldest queued write.
    always @(negedge clk) begin
        logic [68:0] e;
        if (!rst && rf_we32) begin
            if (q32.size() == 0) begin
                checkOutput("we32_unexpected", {63'd0, rf_we32}, 64'd0);
            end else begin
                e = q32.pop_front();
                checkOutput("waddr32", {59'd0, rf_waddr32}, {59'd0, e[68:64]});
                checkOutput("wdata32", {32'd0, rf_wdata32}, e[63:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [68:0] e;
        if (!rst && rf_we64) begin
            if (q64.size() == 0) begin
                checkOutput("we64_unexpected", {63'd0, rf_we64}, 64'd0);
            end else begin
                e = q64.pop_front();
                checkOutput("waddr64", {59'd0, rf_waddr64}, {59'd0, e[68:64]});
                checkOutput("wdata64", rf_wdata64, e[63:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        driveIdle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_we32", rf_we32, 0);
        checkOutput("rst_waddr32", rf_waddr32, 0);
        checkOutput("rst_wdata32", rf_wdata32, 0);
        checkOutput("rst_mis32", mis32, 0);
        checkOutput("rst_busy32", busy32, 0);
        checkOutput("rst_we64", rf_we64, 0);
        checkOutput("rst_wdata64", rf_wdata64, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready32_after_reset", ready32, 1);
        checkOutput("ready64_after_reset", ready64, 1);
        nextCycle();

        // Back-to-back non-loads
        applyStimulus(1'b0, 1'b1, WB_ALU, 3'd0, 3'd0, 64'h1234, 5'd5, 1'b1, 1'b0, 64'd0, 1'b0);
        pushExp32(5'd5, 32'h1234);
        @(negedge clk);
        checkOutput("b2b_ready_a", ready32, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, WB_PC, 3'd0, 3'd0, 64'h104, 5'd6, 1'b1, 1'b0, 64'd0, 1'b0);
        pushExp32(5'd6, 32'h0000_0104);
        @(negedge clk);
        checkOutput("b2b_ready_b", ready32, 1);
        checkOutput("b2b_we_a", rf_we32, 1);
        nextCycle();
        driveIdle();
        @(negedge clk);
        checkOutput("b2b_we_b", rf_we32, 1);
        nextCycle();

        // CSR source, then an instruction that does not write rd
        applyStimulus(1'b0, 1'b1, WB_CSR, 3'd0, 3'd0, 64'hCAFE_F00D, 5'd9, 1'b1, 1'b0, 64'd0, 1'b0);
        pushExp32(5'd9, 32'hCAFE_F00D);
        nextCycle();
        applyStimulus(1'b0, 1'b1, WB_ALU, 3'd0, 3'd0, 64'h77, 5'd3, 1'b0, 1'b0, 64'd0, 1'b0);
        nextCycle();
        driveIdle();
        @(negedge clk);
        checkOutput("no_rd_we", rf_we32, 0);
        nextCycle();

        // Single-cycle loads
        applyStimulus(1'b0, 1'b1, WB_MEM, 3'b000, 3'd3, 64'd0, 5'd7, 1'b1, 1'b1, 64'h80FF_0000, 1'b0);
        pushExp32(5'd7, 32'hFFFF_FF80);
        nextCycle();
        applyStimulus(1'b0, 1'b1, WB_MEM, 3'b100, 3'd3, 64'd0, 5'd8, 1'b1, 1'b1, 64'h80FF_0000, 1'b0);
        pushExp32(5'd8, 32'h0000_0080);
        nextCycle();
        driveIdle();
        nextCycle();

        // Multi-cycle LH with a non-load held behind it
        applyStimulus(1'b0, 1'b1, WB_MEM, 3'b001, 3'd2, 64'd0, 5'd10, 1'b1, 1'b0, 64'd0, 1'b0);
        @(negedge clk);
        checkOutput("lh_accept_ready", ready32, 1);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, WB_ALU, 3'd0, 3'd0, 64'h55, 5'd11, 1'b1,
                          (i == 2), 64'h8001_1234, 1'b0);
            if (i == 2) pushExp32(5'd10, 32'hFFFF_8001);
            @(negedge clk);
            checkOutput("lh_wait_busy", busy32, 1);
            checkOutput("lh_wait_ready", ready32, 0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b1, WB_ALU, 3'd0, 3'd0, 64'h55, 5'd11, 1'b1, 1'b0, 64'd0, 1'b0);
        pushExp32(5'd11, 32'h55);
        @(negedge clk);
        checkOutput("lh_done_busy", busy32, 0);
        checkOutput("lh_done_ready", ready32, 1);
        checkOutput("lh_done_we", rf_we32, 1);
        nextCycle();
        driveIdle();
        @(negedge clk);
        checkOutput("held_alu_we", rf_we32, 1);
        nextCycle();

        // Misaligned LW: mem_rvalid present but must be ignored
        applyStimulus(1'b0, 1'b1, WB_MEM, 3'b010, 3'd2, 64'd0, 5'd12, 1'b1, 1'b1, 64'hDEAD_BEEF, 1'b0);
        nextCycle();
        driveIdle();
        @(negedge clk);
        checkOutput("mis_pulse", mis32, 1);
        checkOutput("mis_busy", busy32, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("mis_pulse_end", mis32, 0);
        nextCycle();

        // Flush in WAIT_MEM together with mem_rvalid, then a stray response
        applyStimulus(1'b0, 1'b1, WB_MEM, 3'b010, 3'd0, 64'd0, 5'd13, 1'b1, 1'b0, 64'd0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, WB_ALU, 3'd0, 3'd0, 64'd0, 5'd0, 1'b0, 1'b1, 64'h1111_1111, 1'b1);
        @(negedge clk);
        checkOutput("flush_wait_busy", busy32, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, WB_ALU, 3'd0, 3'd0, 64'd0, 5'd0, 1'b0, 1'b1, 64'h2222_2222, 1'b0);
        @(negedge clk);
        checkOutput("flush_idle_busy", busy32, 0);
        checkOutput("flush_idle_ready", ready32, 1);
        nextCycle();

        // Flush in IDLE drops the input
        applyStimulus(1'b0, 1'b1, WB_ALU, 3'd0, 3'd0, 64'h99, 5'd14, 1'b1, 1'b0, 64'd0, 1'b1);
        nextCycle();
        driveIdle();
        @(negedge clk);
        checkOutput("flush_idle_we", rf_we32, 0);
        nextCycle();

        // Reset asserted while a load is outstanding
        applyStimulus(1'b0, 1'b1, WB_MEM, 3'b001, 3'd0, 64'd0, 5'd15, 1'b1, 1'b0, 64'd0, 1'b0);
        nextCycle();
        driveIdle();
        @(negedge clk);
        checkOutput("pre_rst_busy", busy32, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy32, 0);
        checkOutput("midrst_ready", ready32, 1);
        checkOutput("midrst_waddr", rf_waddr32, 0);
        checkOutput("midrst_wdata", rf_wdata32, 0);
        checkOutput("midrst_we", rf_we32, 0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, WB_ALU, 3'd0, 3'd0, 64'd0, 5'd0, 1'b0, 1'b1, 64'h3333_3333, 1'b0);
        nextCycle();
        driveIdle();
        @(negedge clk);
        checkOutput("postrst_we", rf_we32, 0);
        nextCycle();

        // 64-bit datapath
        applyStimulus(1'b1, 1'b1, WB_MEM, 3'b110, 3'd4, 64'd0, 5'd16, 1'b1, 1'b1,
                      64'hF000_0001_1234_5678, 1'b0);
        pushExp64(5'd16, 64'h0000_0000_F000_0001);
        nextCycle();
        applyStimulus(1'b1, 1'b1, WB_MEM, 3'b010, 3'd4, 64'd0, 5'd17, 1'b1, 1'b1,
                      64'hF000_0001_1234_5678, 1'b0);
        pushExp64(5'd17, 64'hFFFF_FFFF_F000_0001);
        nextCycle();
        applyStimulus(1'b1, 1'b1, WB_MEM, 3'b011, 3'd0, 64'd0, 5'd18, 1'b1, 1'b1,
                      64'h8123_4567_89AB_CDEF, 1'b0);
        pushExp64(5'd18, 64'h8123_4567_89AB_CDEF);
        nextCycle();
        applyStimulus(1'b1, 1'b1, WB_ALU, 3'd0, 3'd0, 64'h0123_4567_89AB_CDEF, 5'd19, 1'b1,
                      1'b0, 64'd0, 1'b0);
        pushExp64(5'd19, 64'h0123_4567_89AB_CDEF);
        nextCycle();
        applyStimulus(1'b1, 1'b1, WB_ALU, 3'd0, 3'd0, 64'h4444, 5'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, WB_MEM, 3'b011, 3'd4, 64'd0, 5'd20, 1'b1, 1'b1,
                      64'h5555_5555_5555_5555, 1'b0);
        @(negedge clk);
        checkOutput("rd0_no_we64", rf_we64, 0);
        nextCycle();
        driveIdle();
        @(negedge clk);
        checkOutput("ld_mis64", mis64, 1);
        checkOutput("ld_mis64_busy", busy64, 0);
        nextCycle();

        repeat (3) nextCycle();
        checkOutput("q32_drained", q32.size(), 0);
        checkOutput("q64_drained", q64.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
